usr_seq: RTL and testbench
==========================

# usr_seq

Parametrised universal shift register with a command-sequenced multi-bit shift engine. Generalises the 4-bit hold/shift-right/shift-left/load register to WIDTH bits. Adds rotate, arithmetic shift right and clear operations, plus a valid/ready command port that executes an N-position shift over N clock cycles. The block sits wherever the datapath needs serialising/deserialising or bit-position alignment, and its serial-out taps chain directly into neighbouring shift blocks.

## Interface
- WIDTH, 8, register width in bits (≥2)
- AW, $clog2(WIDTH)+1, width of shift-amount field (can express 0..WIDTH)

- clk  in  1  rising-edge clock, sole clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  3  operation code (below)
- cmd_amt  in  AW  shift count for ops 001/010/100/101/110
- D  in  WIDTH  parallel load data, sampled only at accept
- SR  in  1  serial in at MSB for shift-right, sampled every shift cycle
- SL  in  1  serial in at LSB for shift-left, sampled every shift cycle
- Q  out  WIDTH  register contents
- SO_R  out  1  Q[0] (bit leaving on shift right), combinational
- SO_L  out  1  Q[WIDTH-1] (bit leaving on shift left), combinational
- busy  out  1  multi-cycle shift in progress
- done  out  1  one-cycle completion pulse

## Operation
- Opcodes:
  - 000: hold.
  - 001: shift right (Q[W-1]<=SR, Q[i]<=Q[i+1]).
  - 010: shift left (Q[0]<=SL, Q[i]<=Q[i-1]).
  - 011: parallel load D.
  - 100: rotate right (Q[W-1]<=Q[0]).
  - 101: rotate left (Q[0]<=Q[W-1]).
  - 110: arithmetic shift right (Q[W-1] kept).
  - 111: clear to 0.
- Accept = cmd_valid & cmd_ready at a rising edge. cmd_ready = (state==IDLE) & ~reset.
- States: IDLE, SHIFT. Registered op and remaining-count cnt (AW bits).
- Accept of op 000/011/111, or of a shift op with cmd_amt==0: action applied at the accept edge (000 and amt 0 leave Q unchanged). done=1 next cycle. Remain in IDLE.
- Accept of a shift op with cmd_amt==N≥1: first step applied at the accept edge.
  - N==1: done=1 next cycle, stay IDLE.
  - Otherwise: cnt<=N-1, go to SHIFT.
- SHIFT: one step per edge, cnt decrements. The edge at which cnt==1 applies the final step, sets done=1 and returns to IDLE.
- cmd_amt > WIDTH is legal and executes exactly cmd_amt steps (rotates wrap; shifts fill fully with serial input).
- cmd_valid while not ready is ignored (not queued). cmd_* may change freely during SHIFT.
- busy = (state==SHIFT).

## Timing
- Reset (sync, high): Q=0, state=IDLE, cnt=0, done=0, busy=0. cmd_ready=0 while reset is high. Reset overrides any accept in the same cycle.
- Reset mid-SHIFT: the operation is aborted, no done pulse, Q=0 on the next edge.
- N-step shift accepted at edge k: Q steps at edges k..k+N-1.
  - busy high for the N-1 cycles after edges k..k+N-2.
  - done high for one cycle after edge k+N-1. The final Q is visible in that same cycle.
- Single-cycle ops: Q updated at edge k, done high for the cycle after k, busy never asserted.
- cmd_ready is high in the done cycle, so back-to-back commands lose no cycles. Throughput is max(N,1) cycles per command.
- done is never high for two consecutive cycles unless two back-to-back commands both complete.

## Test plan
- Reset, then load D=0xA5 (WIDTH=8) -> Q=0xA5 one edge later, done one cycle, busy never high.
- From 0xA5, shift right amt 3 with SR=1 -> Q=0xD2, 0xE9, 0xF4 on successive edges. busy for 2 cycles, cmd_ready low for those 2 cycles, then done for one cycle with Q=0xF4.
- From 0x81:
  - rotate left amt 1 -> 0x03.
  - then rotate left amt 8 -> 0x03 after 8 edges, done once.
  - a cmd_valid pulse mid-run is ignored.
- From 0x90, arithmetic shift right amt 2 -> 0xE4. From 0x90, op 111 -> 0x00 in one edge.
- From 0x01 with SL=0, shift left amt 5, reset asserted after the 2nd step -> Q=0x00, busy=0, no done pulse. cmd_ready returns high the cycle after reset drops.
- Back-to-back: issue shift right amt 0 then load 0x3C in the done cycle -> Q unchanged, then Q=0x3C, done pulses on consecutive cycles.

Source files
------------

// File: rtl/usr_seq_if.sv
// Command port of usr_seq: valid/ready handshake carrying an opcode and shift count.
interface usr_seq_if #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_amt;

  modport master (output cmd_valid, output cmd_op, output cmd_amt, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_amt, output cmd_ready);
endinterface

// File: rtl/usr_seq.sv
// Universal shift register with a command-sequenced multi-cycle shift/rotate engine.
module usr_seq #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  usr_seq_if.slave         cmd,
  input  logic [WIDTH-1:0] D,
  input  logic             SR,
  input  logic             SL,
  output logic [WIDTH-1:0] Q,
  output logic             SO_R,
  output logic             SO_L,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  op_t              op_q, op_nxt;
  op_t              cmd_op;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;
  logic             accept;

  // One single-position step of any shift-class opcode.
  function automatic logic [WIDTH-1:0] step(op_t op, logic [WIDTH-1:0] v, logic sr, logic sl);
    case (op)
      OP_SHR:  return {sr, v[WIDTH-1:1]};
      OP_SHL:  return {v[WIDTH-2:0], sl};
      OP_ROR:  return {v[0], v[WIDTH-1:1]};
      OP_ROL:  return {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ASR:  return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  assign cmd_op        = op_t'(cmd.cmd_op);
  assign cmd.cmd_ready = (state == IDLE) & ~reset;
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign busy          = (state == SHIFT);
  assign SO_R          = Q[0];
  assign SO_L          = Q[WIDTH-1];

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    cnt_nxt   = cnt;
    q_nxt     = Q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          done_nxt = 1'b1;
          case (cmd_op)
            OP_HOLD: q_nxt = Q;
            OP_LOAD: q_nxt = D;
            OP_CLR:  q_nxt = '0;
            default: begin
              // First step lands on the accept edge; only N>=2 needs the SHIFT state.
              if (cmd.cmd_amt != '0) begin
                q_nxt = step(cmd_op, Q, SR, SL);
                if (cmd.cmd_amt != AW'(1)) begin
                  done_nxt  = 1'b0;
                  op_nxt    = cmd_op;
                  cnt_nxt   = cmd.cmd_amt - AW'(1);
                  state_nxt = SHIFT;
                end
              end
            end
          endcase
        end
      end
      SHIFT: begin
        q_nxt   = step(op_q, Q, SR, SL);
        cnt_nxt = cnt - AW'(1);
        if (cnt == AW'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_HOLD;
      cnt   <= '0;
      Q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      op_q  <= op_nxt;
      cnt   <= cnt_nxt;
      Q     <= q_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_usr_seq.sv
// Self-checking bench for usr_seq: directed scenarios plus random traffic against a cycle reference model.
module tb_usr_seq;
  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d;
  logic         sr, sl;
  logic [W-1:0] q;
  logic         so_r, so_l, busy, done;

  usr_seq_if #(.WIDTH(W), .AW(AW)) bus ();

  usr_seq #(.WIDTH(W), .AW(AW)) dut (
    .clk   (clk),
    .reset (rst),
    .cmd   (bus),
    .D     (d),
    .SR    (sr),
    .SL    (sl),
    .Q     (q),
    .SO_R  (so_r),
    .SO_L  (so_l),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: register value, steps still owed, opcode in flight, done flag.
  logic [W-1:0] mq;
  int           mrem;
  int           mop;
  logic         mdone;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_step(int op, logic [W-1:0] v0, logic s_r, logic s_l);
    int unsigned v   = v0;
    int unsigned top = 2 ** (W - 1);
    int unsigned mod = 2 ** W;
    case (op)
      1: v = (v / 2) + (s_r ? top : 0);
      2: v = ((v * 2) % mod) + (s_l ? 1 : 0);
      4: v = (v / 2) + ((v % 2) * top);
      5: v = ((v * 2) % mod) + (v / top);
      6: v = (v / 2) + (v / top) * top;
      default: ;
    endcase
    return v[W-1:0];
  endfunction

  // Model of one clock edge, given the inputs presented to it.
  task automatic model_edge(input logic valid, input int op, input int amt);
    logic acc;
    acc = valid && (mrem == 0) && !rst;
    if (rst) begin
      mq = '0; mrem = 0; mdone = 1'b0;
    end else if (mrem > 0) begin
      mq = model_step(mop, mq, sr, sl);
      mrem--;
      mdone = (mrem == 0);
    end else if (acc) begin
      mdone = 1'b1;
      if (op == 3) mq = d;
      else if (op == 7) mq = '0;
      else if (op != 0 && amt > 0) begin
        mq    = model_step(op, mq, sr, sl);
        mrem  = amt - 1;
        mop   = op;
        mdone = (amt == 1);
      end
    end else begin
      mdone = 1'b0;
    end
  endtask

  task automatic cyc(input logic valid, input int op, input int amt,
                     input logic [W-1:0] dd, input logic s_r, input logic s_l, input logic r);
    bus.cmd_valid = valid;
    bus.cmd_op    = op[2:0];
    bus.cmd_amt   = amt[AW-1:0];
    d = dd; sr = s_r; sl = s_l; rst = r;
    @(posedge clk);
    model_edge(valid, op, amt);
    #1;
    chk("q",     32'(q),             32'(mq));
    chk("busy",  32'(busy),          32'(mrem > 0));
    chk("done",  32'(done),          32'(mdone));
    chk("ready", 32'(bus.cmd_ready), 32'((mrem == 0) && !rst));
    chk("so_r",  32'(so_r),          32'(mq[0]));
    chk("so_l",  32'(so_l),          32'(mq[W-1]));
  endtask

  task automatic idle(input logic s_r, input logic s_l);
    cyc(1'b0, 0, 0, '0, s_r, s_l, 1'b0);
  endtask

  initial begin
    int dn;
    mq = '0; mrem = 0; mop = 0; mdone = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_amt = '0;
    d = '0; sr = 1'b0; sl = 1'b0; rst = 1'b1;

    cyc(1'b1, 3, 0, 8'hFF, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, '0, 0, 0, 1'b1);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_ready", 32'(bus.cmd_ready), 32'h0);

    // Load, then SHR by 3 with SR=1.
    cyc(1'b1, 3, 0, 8'hA5, 0, 0, 1'b0);
    chk("load_a5", 32'(q), 32'hA5);
    chk("load_done", 32'(done), 32'h1);
    cyc(1'b1, 1, 3, '0, 1, 0, 1'b0);
    chk("shr_1", 32'(q), 32'hD2);
    chk("shr_rdy", 32'(bus.cmd_ready), 32'h0);
    cyc(1'b0, 0, 0, '0, 1, 0, 1'b0);
    chk("shr_2", 32'(q), 32'hE9);
    chk("shr_busy", 32'(busy), 32'h1);
    cyc(1'b0, 0, 0, '0, 1, 0, 1'b0);
    chk("shr_3", 32'(q), 32'hF4);
    chk("shr_done", 32'(done), 32'h1);
    chk("shr_busy_end", 32'(busy), 32'h0);

    // Rotate left 1 then 8, with an ignored command mid-run.
    cyc(1'b1, 3, 0, 8'h81, 0, 0, 1'b0);
    cyc(1'b1, 5, 1, '0, 0, 0, 1'b0);
    chk("rol1", 32'(q), 32'h03);
    dn = 0;
    cyc(1'b1, 5, 8, '0, 0, 0, 1'b0);
    dn += int'(done);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) cyc(1'b1, 3, 0, 8'hFF, 0, 0, 1'b0);
      else        idle(1'b0, 1'b0);
      dn += int'(done);
    end
    chk("rol8", 32'(q), 32'h03);
    chk("rol8_dn", 32'(dn), 32'd1);
    idle(1'b0, 1'b0);
    chk("rol8_q_hold", 32'(q), 32'h03);

    // ASR and clear.
    cyc(1'b1, 3, 0, 8'h90, 0, 0, 1'b0);
    cyc(1'b1, 6, 2, '0, 0, 0, 1'b0);
    idle(1'b0, 1'b0);
    chk("asr2", 32'(q), 32'hE4);
    cyc(1'b1, 3, 0, 8'h90, 0, 0, 1'b0);
    cyc(1'b1, 7, 0, '0, 0, 0, 1'b0);
    chk("clr", 32'(q), 32'h00);

    // SHL 5 aborted by reset after the second step.
    cyc(1'b1, 3, 0, 8'h01, 0, 0, 1'b0);
    cyc(1'b1, 2, 5, '0, 0, 0, 1'b0);
    idle(1'b0, 1'b0);
    chk("shl_2", 32'(q), 32'h04);
    cyc(1'b0, 0, 0, '0, 0, 0, 1'b1);
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    idle(1'b0, 1'b0);
    chk("abort_rdy", 32'(bus.cmd_ready), 32'h1);
    chk("abort_nodone", 32'(done), 32'h0);

    // Back-to-back: amt 0 shift then load in the done cycle.
    cyc(1'b1, 3, 0, 8'h5A, 0, 0, 1'b0);
    cyc(1'b1, 1, 0, '0, 1, 0, 1'b0);
    chk("amt0_q", 32'(q), 32'h5A);
    chk("amt0_done", 32'(done), 32'h1);
    cyc(1'b1, 3, 0, 8'h3C, 0, 0, 1'b0);
    chk("b2b_q", 32'(q), 32'h3C);
    chk("b2b_done", 32'(done), 32'h1);

    // Random traffic, including counts beyond WIDTH and occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 2 ** AW - 1)), W'($urandom),
          1'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
